// File: rtl/jk_edge_monitor.sv
// Edge monitor for a complementary JK flip-flop output pair: counts accepted rises/falls and flags faults.
// Define JK_MON_SYNC_EN to place a two-flop synchronizer on Q/Q_b ahead of the sample stage.
//
// state | meaning
// UNK   | level not yet known (after reset or clear)
// LOW   | last accepted level was 0
// HIGH  | last accepted level was 1
// FAULT | two consecutive non-complementary samples; exit only by Clr or Rst
module jk_edge_monitor (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Q,
  input  logic       Q_b,
  input  logic       Clr,
  output logic [7:0] Rise_Cnt,
  output logic [7:0] Fall_Cnt,
  output logic       Edge,
  output logic       Dir,
  output logic [1:0] State,
  output logic       Ovf,
  output logic       Err
);

  typedef enum logic [1:0] {
    ST_UNK   = 2'b00,
    ST_LOW   = 2'b01,
    ST_HIGH  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  logic q_in, qb_in;

`ifdef JK_MON_SYNC_EN
  localparam logic [1:0] FILL_N = 2'd3;
  logic [1:0] sync_q, sync_qb;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_q  <= '0;
      sync_qb <= '0;
    end else begin
      sync_q  <= {sync_q[0], Q};
      sync_qb <= {sync_qb[0], Q_b};
    end
  end

  assign q_in  = sync_q[1];
  assign qb_in = sync_qb[1];
`else
  localparam logic [1:0] FILL_N = 2'd1;
  assign q_in  = Q;
  assign qb_in = Q_b;
`endif

  logic       q_s, qb_s;
  logic [1:0] fill_cnt;
  logic       primed;
  logic       valid;

  state_t     state_q, state_d;
  logic [7:0] rise_q, rise_d, fall_q, fall_d;
  logic       edge_q, edge_d, dir_q, dir_d;
  logic       ovf_q, ovf_d, err_q, err_d;
  logic       inv_q, inv_d;

  // Reset zeroes every pipeline flop, which reads as an invalid pair; the FSM
  // waits until the pipeline holds post-reset data so that is not mistaken for a fault.
  assign primed = (fill_cnt == FILL_N);
  assign valid  = q_s ^ qb_s;

  always_comb begin
    state_d = state_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    edge_d  = 1'b0;
    dir_d   = dir_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    inv_d   = inv_q;
    if (Clr) begin
      state_d = ST_UNK;
      rise_d  = '0;
      fall_d  = '0;
      dir_d   = 1'b0;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
      inv_d   = 1'b0;
    end else if (primed && state_q != ST_FAULT) begin
      if (!valid) begin
        if (inv_q) begin
          state_d = ST_FAULT;
          err_d   = 1'b1;
          inv_d   = 1'b0;
        end else begin
          inv_d = 1'b1;
        end
      end else begin
        inv_d = 1'b0;
        case (state_q)
          ST_UNK: state_d = q_s ? ST_HIGH : ST_LOW;
          ST_LOW: if (q_s) begin
            state_d = ST_HIGH;
            rise_d  = rise_q + 8'd1;
            ovf_d   = ovf_q | (rise_q == 8'hff);
            edge_d  = 1'b1;
            dir_d   = 1'b1;
          end
          ST_HIGH: if (!q_s) begin
            state_d = ST_LOW;
            fall_d  = fall_q + 8'd1;
            ovf_d   = ovf_q | (fall_q == 8'hff);
            edge_d  = 1'b1;
            dir_d   = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      q_s      <= 1'b0;
      qb_s     <= 1'b0;
      fill_cnt <= '0;
      state_q  <= ST_UNK;
      rise_q   <= '0;
      fall_q   <= '0;
      edge_q   <= 1'b0;
      dir_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      q_s      <= q_in;
      qb_s     <= qb_in;
      if (!primed) fill_cnt <= fill_cnt + 2'd1;
      state_q  <= state_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      edge_q   <= edge_d;
      dir_q    <= dir_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      inv_q    <= inv_d;
    end
  end

  assign Rise_Cnt = rise_q;
  assign Fall_Cnt = fall_q;
  assign Edge     = edge_q;
  assign Dir      = dir_q;
  assign State    = state_q;
  assign Ovf      = ovf_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_jk_edge_monitor.sv
// Self-checking bench for jk_edge_monitor: cycle model feeds a scoreboard queue, tasks add end-of-scenario checks.
module tb_jk_edge_monitor;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Q   = 1'b0;
  logic       Q_b = 1'b0;
  logic       Clr = 1'b0;
  logic [7:0] Rise_Cnt, Fall_Cnt;
  logic       Edge, Dir, Ovf, Err;
  logic [1:0] State;

  jk_edge_monitor dut (
    .Clk(Clk), .Rst(Rst), .Q(Q), .Q_b(Q_b), .Clr(Clr),
    .Rise_Cnt(Rise_Cnt), .Fall_Cnt(Fall_Cnt), .Edge(Edge), .Dir(Dir),
    .State(State), .Ovf(Ovf), .Err(Err)
  );

  always #5 Clk = ~Clk;

`ifdef JK_MON_SYNC_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       ed;
    logic       dir;
    logic       ovf;
    logic       err;
  } exp_t;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   edge_seen = 0;
  exp_t sb_q[$];

  logic [1:0] m_st;
  logic [7:0] m_rise, m_fall;
  logic       m_edge, m_dir, m_ovf, m_err, m_inv;
  logic       pq[DEPTH], pqb[DEPTH], pv[DEPTH];

  // Predicts the outputs right after the coming rising edge from the inputs now on the pins.
  task automatic model_edge();
    logic sq, sqb, sv;
    if (Rst) begin
      m_st = 2'b00; m_rise = 8'd0; m_fall = 8'd0;
      m_edge = 1'b0; m_dir = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_inv = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin pq[i] = 1'b0; pqb[i] = 1'b0; pv[i] = 1'b0; end
    end else begin
      sq = pq[DEPTH-1]; sqb = pqb[DEPTH-1]; sv = pv[DEPTH-1];
      m_edge = 1'b0;
      if (Clr) begin
        m_st = 2'b00; m_rise = 8'd0; m_fall = 8'd0;
        m_dir = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_inv = 1'b0;
      end else if (sv && m_st != 2'b11) begin
        if (sq == sqb) begin
          if (m_inv) begin m_st = 2'b11; m_err = 1'b1; end
          m_inv = !m_inv;
        end else begin
          m_inv = 1'b0;
          if (m_st == 2'b00) m_st = sq ? 2'b10 : 2'b01;
          else if (m_st == 2'b01 && sq) begin
            if (m_rise == 8'd255) m_ovf = 1'b1;
            m_rise = m_rise + 8'd1; m_st = 2'b10; m_edge = 1'b1; m_dir = 1'b1;
          end else if (m_st == 2'b10 && !sq) begin
            if (m_fall == 8'd255) m_ovf = 1'b1;
            m_fall = m_fall + 8'd1; m_st = 2'b01; m_edge = 1'b1; m_dir = 1'b0;
          end
        end
      end
      for (int i = DEPTH - 1; i > 0; i--) begin pq[i] = pq[i-1]; pqb[i] = pqb[i-1]; pv[i] = pv[i-1]; end
      pq[0] = Q; pqb[0] = Q_b; pv[0] = 1'b1;
    end
  endtask

  task automatic step(input logic rst, input logic clr, input logic q, input logic qb);
    Rst = rst; Clr = clr; Q = q; Q_b = qb;
    model_edge();
    sb_q.push_back('{st: m_st, rise: m_rise, fall: m_fall, ed: m_edge, dir: m_dir, ovf: m_ovf, err: m_err});
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n, input logic q, input logic qb);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, q, qb);
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (Edge === 1'b1) edge_seen++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      tests_run++;
      if ({State, Rise_Cnt, Fall_Cnt, Edge, Dir, Ovf, Err} !== e) begin
        tests_failed++;
        $display("FAIL scoreboard t=%0t got st=%b r=%0d f=%0d e=%b d=%b o=%b er=%b exp st=%b r=%0d f=%0d e=%b d=%b o=%b er=%b",
                 $time, State, Rise_Cnt, Fall_Cnt, Edge, Dir, Ovf, Err,
                 e.st, e.rise, e.fall, e.ed, e.dir, e.ovf, e.err);
      end
    end
  end

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    edge_seen = 0;
    idle(DEPTH + 5, 1'b0, 1'b1);
    tests_run++;
    if (State !== 2'b01) begin tests_failed++; $display("FAIL reset_state got=%b exp=01", State); end
    tests_run++;
    if (Rise_Cnt !== 8'd0 || Fall_Cnt !== 8'd0) begin
      tests_failed++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", Rise_Cnt, Fall_Cnt);
    end
    tests_run++;
    if (edge_seen !== 0) begin tests_failed++; $display("FAIL reset_edges got=%0d exp=0", edge_seen); end
  endtask

  task automatic test_toggle();
    edge_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, (i % 2 == 0), (i % 2 != 0));
      step(1'b0, 1'b0, (i % 2 == 0), (i % 2 != 0));
    end
    idle(DEPTH + 2, 1'b0, 1'b1);
    tests_run++;
    if (Rise_Cnt !== 8'd5 || Fall_Cnt !== 8'd5) begin
      tests_failed++; $display("FAIL toggle_counts got=%0d/%0d exp=5/5", Rise_Cnt, Fall_Cnt);
    end
    tests_run++;
    if (edge_seen !== 10) begin tests_failed++; $display("FAIL toggle_edges got=%0d exp=10", edge_seen); end
    tests_run++;
    if (Dir !== 1'b0 || State !== 2'b01) begin
      tests_failed++; $display("FAIL toggle_dir got dir=%b st=%b exp dir=0 st=01", Dir, State);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(DEPTH + 2, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    idle(DEPTH + 2, 1'b0, 1'b1);
    tests_run++;
    if (Rise_Cnt !== 8'd0 || Ovf !== 1'b1) begin
      tests_failed++; $display("FAIL wrap got rise=%0d ovf=%b exp rise=0 ovf=1", Rise_Cnt, Ovf);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    idle(DEPTH + 2, 1'b0, 1'b1);
    tests_run++;
    if (Rise_Cnt !== 8'd2 || Ovf !== 1'b1) begin
      tests_failed++; $display("FAIL ovf_sticky got rise=%0d ovf=%b exp rise=2 ovf=1", Rise_Cnt, Ovf);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if ({State, Rise_Cnt, Fall_Cnt, Ovf} !== 19'd0) begin
      tests_failed++;
      $display("FAIL wrap_clr got st=%b r=%0d f=%0d ovf=%b exp all 0", State, Rise_Cnt, Fall_Cnt, Ovf);
    end
  endtask

  task automatic test_glitch_fault();
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(DEPTH + 2, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(DEPTH + 2, 1'b1, 1'b0);
    tests_run++;
    if (State !== 2'b10 || Rise_Cnt !== 8'd1 || Err !== 1'b0) begin
      tests_failed++; $display("FAIL glitch got st=%b rise=%0d err=%b exp st=10 rise=1 err=0", State, Rise_Cnt, Err);
    end
    idle(2, 1'b0, 1'b0);
    idle(DEPTH + 2, 1'b0, 1'b1);
    tests_run++;
    if (State !== 2'b11 || Err !== 1'b1) begin
      tests_failed++; $display("FAIL fault got st=%b err=%b exp st=11 err=1", State, Err);
    end
    for (int i = 0; i < 3; i++) begin
      idle(2, 1'b1, 1'b0);
      idle(2, 1'b0, 1'b1);
    end
    tests_run++;
    if (Rise_Cnt !== 8'd1 || Fall_Cnt !== 8'd0 || State !== 2'b11) begin
      tests_failed++; $display("FAIL fault_hold got r=%0d f=%0d st=%b exp r=1 f=0 st=11", Rise_Cnt, Fall_Cnt, State);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if (State !== 2'b00 || Err !== 1'b0) begin
      tests_failed++; $display("FAIL fault_clr got st=%b err=%b exp st=00 err=0", State, Err);
    end
  endtask

  task automatic test_clr_rst_priority();
    idle(DEPTH + 2, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(DEPTH - 1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (Rise_Cnt !== 8'd0 || Edge !== 1'b0 || State !== 2'b00) begin
      tests_failed++; $display("FAIL clr_on_sample got r=%0d edge=%b st=%b exp r=0 edge=0 st=00", Rise_Cnt, Edge, State);
    end
    idle(DEPTH + 2, 1'b1, 1'b0);
    tests_run++;
    if (Rise_Cnt !== 8'd0 || State !== 2'b10) begin
      tests_failed++; $display("FAIL clr_reenter got r=%0d st=%b exp r=0 st=10", Rise_Cnt, State);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if ({State, Rise_Cnt, Fall_Cnt, Edge, Dir, Ovf, Err} !== 22'd0) begin
      tests_failed++;
      $display("FAIL rst_clr got st=%b r=%0d f=%0d e=%b d=%b o=%b er=%b exp all 0",
               State, Rise_Cnt, Fall_Cnt, Edge, Dir, Ovf, Err);
    end
    idle(DEPTH + 3, 1'b1, 1'b0);
    tests_run++;
    if (State !== 2'b10 || Rise_Cnt !== 8'd0 || Fall_Cnt !== 8'd0) begin
      tests_failed++; $display("FAIL rst_reenter got st=%b r=%0d f=%0d exp st=10 r=0 f=0", State, Rise_Cnt, Fall_Cnt);
    end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_wrap();
    test_glitch_fault();
    test_clr_rst_priority();
    #10;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jk_edge_monitor.md
JK_EDGE_MONITOR -- requirements
Module: jk_edge_monitor

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Rst  input  1  synchronous, active-high reset; sampled on rising Clk edge only.
REQ-003 Q  input  1  true output of upstream JK_FF.
REQ-004 Q_b  input  1  complement output of upstream JK_FF.
REQ-005 Clr  input  1  synchronous clear of counters, flags and state; one-cycle pulse or level.
REQ-006 Rise_Cnt  output  8  count of accepted 0->1 transitions of Q.
REQ-007 Fall_Cnt  output  8  count of accepted 1->0 transitions of Q.
REQ-008 Edge  output  1  one-cycle pulse per accepted transition.
REQ-009 Dir  output  1  direction of last accepted transition (1 = rise, 0 = fall).
REQ-010 State  output  2  monitor state: UNK=00, LOW=01, HIGH=10, FAULT=11.
REQ-011 Ovf  output  1  sticky; set when either counter wraps.
REQ-012 Err  output  1  sticky; set on complementarity fault.

Function
REQ-013 Q and Q_b SHALL be registered into a sample stage (Q_s, Qb_s) each cycle; the FSM SHALL act only on sampled values.
REQ-014 Sample is valid when Q_s != Qb_s; invalid otherwise.
REQ-015 UNK: valid sample SHALL move to HIGH if Q_s=1, to LOW if Q_s=0; no count, no Edge.
REQ-016 LOW: valid sample with Q_s=1 SHALL move to HIGH, increment Rise_Cnt, pulse Edge, set Dir=1.
REQ-017 HIGH: valid sample with Q_s=0 SHALL move to LOW, increment Fall_Cnt, pulse Edge, set Dir=0.
REQ-018 An invalid sample SHALL hold state and counters; two consecutive invalid samples in UNK, LOW or HIGH SHALL move to FAULT and set Err.
REQ-019 A single invalid sample followed by a valid one SHALL be ignored (glitch tolerance); the transition is evaluated on the valid sample.
REQ-020 FAULT SHALL be left only by Clr or Rst (to UNK); no counting in FAULT.
REQ-021 Counters SHALL wrap 255->0; the wrapping increment SHALL set Ovf.
REQ-022 Latency: Q change present at edge N SHALL update State/counters/Edge at edge N+1 (N+3 with sync macro).
REQ-023 Clr SHALL set State=UNK, counters=0, Ovf=0, Err=0, Edge=0, Dir=0 and clear the invalid-sample history; a transition in the same cycle SHALL NOT be counted.
REQ-024 Rst SHALL take priority over Clr; Clr over any transition.
REQ-025 Edge SHALL never be high two consecutive cycles unless two consecutive accepted transitions occur.

Reset
REQ-026 On Rst: State=UNK, Rise_Cnt=0, Fall_Cnt=0, Edge=0, Dir=0, Ovf=0, Err=0, sample and sync registers=0, invalid history cleared.
REQ-027 Rst asserted mid-transition SHALL discard it; first valid sample after release re-enters LOW/HIGH from UNK without counting.

Configuration
REQ-028 Macro JK_MON_SYNC_EN, when defined, SHALL insert a two-flop synchronizer on Q and Q_b ahead of the sample stage, adding 2 cycles latency; all synchronizer flops reset to 0.
REQ-029 Without JK_MON_SYNC_EN, Q and Q_b SHALL feed the sample stage directly; latency per REQ-022 (1 cycle).

Verification
REQ-030 Rst 2 cycles, then Q=0/Q_b=1 steady -> State=01, counters 0, Edge never high.
REQ-031 From LOW, toggle Q/Q_b 10 times every 2 cycles -> Rise_Cnt=5, Fall_Cnt=5, 10 Edge pulses, each 1 cycle after sample, Dir matches last edge.
REQ-032 Drive 256 rises -> Rise_Cnt wraps to 0, Ovf=1 at wrap and stays 1; Clr -> Ovf=0, counters 0, State=00.
REQ-033 Q=Q_b=1 one cycle then Q=1/Q_b=0 from LOW -> no FAULT, Rise_Cnt=1; Q=Q_b=0 two cycles -> State=11, Err=1; further toggles not counted until Clr.
REQ-034 Clr asserted in the cycle a rise is sampled -> Rise_Cnt=0, Edge=0; Rst and Clr together -> reset values.
REQ-035 With JK_MON_SYNC_EN defined, repeat REQ-031 -> identical counts, Edge delayed by 2 additional cycles.
